// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Step counter width; a single-step configuration still needs one bit.
    function automatic int cnt_width(input int steps);
        int w;
        w = $clog2(steps);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational single-bit full-subtractor cell: d = a - b - bi, bo = borrow out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    generate
        if (WIDTH < 32'sd1 || DIGIT < 32'sd1 || (WIDTH % DIGIT) != 32'sd0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    sub_state_t               state_r;
    sub_state_t               state_s;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [WIDTH-1:0]         a_r;
    logic [WIDTH-1:0]         b_r;
    logic [WIDTH-1:0]         result_r;
    logic                     borrow_r;
    logic [CW-1:0]            cnt_r;
    logic                     last_s;
    logic [DIGIT:0]           chain_s;
    logic [DIGIT-1:0]         d_s;
    logic [WIDTH+DIGIT-1:0]   cat_s;

    assign last_s = (cnt_r == CW'(STEPS - 32'sd1));

    // Ripple chain of cells over the low digit of the operand shift registers.
    assign chain_s[0] = borrow_r;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fs_cell u_cell (
            .a  (a_r[i]),
            .b  (b_r[i]),
            .bi (chain_s[i]),
            .d  (d_s[i]),
            .bo (chain_s[i+1])
        );
    end

    // New digits enter at the top; the concat keeps WIDTH == DIGIT legal.
    assign cat_s = {d_s, result_r};

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with registered handshake flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Sign capture at acceptance; overflow resolved on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (state_r == IDLE && in_valid) begin
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= b[WIDTH-1];
            end else if (state_r == RUN && last_s) begin
                ovf_r <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s[DIGIT-1]);
            end
        end
    end

    assign ovf = ovf_r;
`endif

    // Operand, result, borrow and step-counter datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= bin;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    result_r <= cat_s[WIDTH+DIGIT-1:DIGIT];
                    borrow_r <= chain_s[DIGIT];
                    cnt_r    <= cnt_r + CW'(1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = result_r;
    assign bout      = borrow_r;

endmodule
